// File: rtl/tcam_lookup_ctrl.sv
// tcam_lookup_ctrl: lookup/refill sequencer for the 256-entry cache tag TCAM.
// Accepts tag lookups over valid/ready, qualifies the TCAM match with a
// per-entry valid bit, and on a miss requests a refill, writes the new tag at
// a round-robin victim index and reports what was evicted.
// Optional build macro: TCAM_CTRL_STATS_EN adds saturating hit/miss/evict
// counters.
module tcam_lookup_ctrl #(
    parameter int TAG_W = 28,
    parameter int IDX_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_hit,
    output logic [IDX_W-1:0] resp_index,
    output logic             resp_evict_valid,
    output logic [TAG_W-1:0] resp_evict_tag,
    output logic             refill_req,
    output logic [TAG_W-1:0] refill_tag,
    input  logic             refill_ack,
    input  logic             flush,
    output logic [TAG_W-1:0] tcam_tag_in,
    output logic             tcam_tag_update,
    output logic [IDX_W-1:0] tcam_rep_ptr,
    input  logic             tcam_found,
    input  logic [IDX_W-1:0] tcam_hit_index,
    input  logic [TAG_W-1:0] tcam_replaced_tag
`ifdef TCAM_CTRL_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count,
    output logic [31:0]      evict_count
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_REFILL = 3'd2,
        ST_UPDATE = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t             state_r;
    logic [TAG_W-1:0]   tag_q_r;
    logic [TAG_W-1:0]   evict_tag_r;
    logic               evict_v_r;
    logic [IDX_W-1:0]   rep_ptr_r;
    logic [ENTRIES-1:0] valid_r;

    logic               resp_valid_r;
    logic               resp_hit_r;
    logic [IDX_W-1:0]   resp_index_r;
    logic               resp_evict_valid_r;
    logic [TAG_W-1:0]   resp_evict_tag_r;
    logic               refill_req_r;
    logic               tcam_tag_update_r;

    logic               lookup_hit_s;
    logic               req_ready_s;

    // A TCAM match only counts when the matched entry is valid; a stale match
    // on an invalidated entry is treated as a miss.
    assign lookup_hit_s = tcam_found && valid_r[tcam_hit_index];

    // Ready only in IDLE, and dropped while flush or reset is being applied.
    assign req_ready_s = (state_r == ST_IDLE) && !RST && !flush;

    assign req_ready        = req_ready_s;
    assign resp_valid       = resp_valid_r;
    assign resp_hit         = resp_hit_r;
    assign resp_index       = resp_index_r;
    assign resp_evict_valid = resp_evict_valid_r;
    assign resp_evict_tag   = resp_evict_tag_r;
    assign refill_req       = refill_req_r;
    assign refill_tag       = tag_q_r;
    assign tcam_tag_in      = tag_q_r;
    assign tcam_tag_update  = tcam_tag_update_r;
    assign tcam_rep_ptr     = rep_ptr_r;

    // Lookup/refill sequencer with all handshake outputs held in registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r            <= ST_IDLE;
            tag_q_r            <= {TAG_W{1'b0}};
            evict_tag_r        <= {TAG_W{1'b0}};
            evict_v_r          <= 1'b0;
            rep_ptr_r          <= {IDX_W{1'b0}};
            valid_r            <= {ENTRIES{1'b0}};
            resp_valid_r       <= 1'b0;
            resp_hit_r         <= 1'b0;
            resp_index_r       <= {IDX_W{1'b0}};
            resp_evict_valid_r <= 1'b0;
            resp_evict_tag_r   <= {TAG_W{1'b0}};
            refill_req_r       <= 1'b0;
            tcam_tag_update_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        valid_r   <= {ENTRIES{1'b0}};
                        rep_ptr_r <= {IDX_W{1'b0}};
                    end else if (req_valid) begin
                        tag_q_r <= req_tag;
                        state_r <= ST_LOOKUP;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    if (lookup_hit_s) begin
                        resp_hit_r         <= 1'b1;
                        resp_index_r       <= tcam_hit_index;
                        resp_evict_valid_r <= 1'b0;
                        resp_valid_r       <= 1'b1;
                        state_r            <= ST_RESP;
                    end else begin
                        evict_tag_r  <= tcam_replaced_tag;
                        evict_v_r    <= valid_r[rep_ptr_r];
                        refill_req_r <= 1'b1;
                        state_r      <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (refill_ack) begin
                        refill_req_r      <= 1'b0;
                        tcam_tag_update_r <= 1'b1;
                        state_r           <= ST_UPDATE;
                    end else begin
                        state_r <= ST_REFILL;
                    end
                end
                ST_UPDATE: begin
                    // The TCAM captures tag_q at rep_ptr on this edge.
                    tcam_tag_update_r  <= 1'b0;
                    valid_r[rep_ptr_r] <= 1'b1;
                    resp_hit_r         <= 1'b0;
                    resp_index_r       <= rep_ptr_r;
                    resp_evict_valid_r <= evict_v_r;
                    resp_evict_tag_r   <= evict_tag_r;
                    rep_ptr_r          <= rep_ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    resp_valid_r       <= 1'b1;
                    state_r            <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r           <= ST_IDLE;
                    resp_valid_r      <= 1'b0;
                    refill_req_r      <= 1'b0;
                    tcam_tag_update_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef TCAM_CTRL_STATS_EN
    logic [31:0] hit_count_r;
    logic [31:0] miss_count_r;
    logic [31:0] evict_count_r;

    assign hit_count   = hit_count_r;
    assign miss_count  = miss_count_r;
    assign evict_count = evict_count_r;

    // Saturating event counters; only reset clears them, flush does not.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_r   <= 32'd0;
            miss_count_r  <= 32'd0;
            evict_count_r <= 32'd0;
        end else begin
            if ((state_r == ST_LOOKUP) && lookup_hit_s && (hit_count_r != 32'hFFFF_FFFF)) begin
                hit_count_r <= hit_count_r + 32'd1;
            end else begin
                hit_count_r <= hit_count_r;
            end
            if ((state_r == ST_LOOKUP) && !lookup_hit_s && (miss_count_r != 32'hFFFF_FFFF)) begin
                miss_count_r <= miss_count_r + 32'd1;
            end else begin
                miss_count_r <= miss_count_r;
            end
            if ((state_r == ST_UPDATE) && evict_v_r && (evict_count_r != 32'hFFFF_FFFF)) begin
                evict_count_r <= evict_count_r + 32'd1;
            end else begin
                evict_count_r <= evict_count_r;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// tb_tcam_lookup_ctrl: directed plus randomized bench for tcam_lookup_ctrl.
// A behavioural TCAM answers the controller; a separate reference model keeps
// the expected tag contents, valid set and replacement pointer as plain arrays.
module tb_tcam_lookup_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [27:0] req_tag = 28'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic [7:0]  resp_index;
    logic        resp_evict_valid;
    logic [27:0] resp_evict_tag;
    logic        refill_req;
    logic [27:0] refill_tag;
    logic        refill_ack = 1'b0;
    logic        flush = 1'b0;
    logic [27:0] tcam_tag_in;
    logic        tcam_tag_update;
    logic [7:0]  tcam_rep_ptr;
    logic        tcam_found;
    logic [7:0]  tcam_hit_index;
    logic [27:0] tcam_replaced_tag;
`ifdef TCAM_CTRL_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] evict_count;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural TCAM storage (written by the DUT strobe).
    bit [27:0] stub_tag [256];
    bit        stub_wr  [256];

    // Reference model state.
    bit [27:0] m_tag   [256];
    bit        m_wr    [256];
    bit        m_valid [256];
    int        m_ptr = 0;
    int        m_hits = 0;
    int        m_misses = 0;
    int        m_evicts = 0;

    always #5 CLK = ~CLK;

    tcam_lookup_ctrl dut (
        .CLK               (CLK),
        .RST               (RST),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_tag           (req_tag),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_hit          (resp_hit),
        .resp_index        (resp_index),
        .resp_evict_valid  (resp_evict_valid),
        .resp_evict_tag    (resp_evict_tag),
        .refill_req        (refill_req),
        .refill_tag        (refill_tag),
        .refill_ack        (refill_ack),
        .flush             (flush),
        .tcam_tag_in       (tcam_tag_in),
        .tcam_tag_update   (tcam_tag_update),
        .tcam_rep_ptr      (tcam_rep_ptr),
        .tcam_found        (tcam_found),
        .tcam_hit_index    (tcam_hit_index),
        .tcam_replaced_tag (tcam_replaced_tag)
`ifdef TCAM_CTRL_STATS_EN
        ,
        .hit_count         (hit_count),
        .miss_count        (miss_count),
        .evict_count       (evict_count)
`endif
    );

    // TCAM search: lowest written entry whose tag equals the search tag.
    always_comb begin
        tcam_found     = 1'b0;
        tcam_hit_index = 8'd0;
        for (int i = 255; i >= 0; i--) begin
            if (stub_wr[i] && (stub_tag[i] == tcam_tag_in)) begin
                tcam_found     = 1'b1;
                tcam_hit_index = i[7:0];
            end
        end
        tcam_replaced_tag = stub_wr[tcam_rep_ptr] ? stub_tag[tcam_rep_ptr] : 28'd0;
    end

    // TCAM write port.
    always @(posedge CLK) begin
        if (tcam_tag_update) begin
            stub_tag[tcam_rep_ptr] <= tcam_tag_in;
            stub_wr[tcam_rep_ptr]  <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic do_flush();
        @(negedge CLK);
        flush = 1'b1;
        #1;
        chk("flush_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        flush = 1'b0;
        #1;
        chk("flush_ptr_zero", {24'd0, tcam_rep_ptr}, 32'd0);
        model_clear();
    endtask

    // One full transaction; expectations come from the reference model.
    task automatic do_req(input logic [27:0] tag, input int ack_dly, input int hold,
                          output logic o_hit, output logic [7:0] o_idx,
                          output logic o_ev, output logic [27:0] o_evtag);
        bit   e_found = 1'b0;
        int   e_i = 0;
        bit   e_hit;
        int   e_idx;
        bit   e_ev = 1'b0;
        bit [27:0] e_evtag = 28'd0;
        int   lat;
        int   k = 0;
        int   guard = 0;
        bit   saw_refill = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (!e_found && m_wr[i] && (m_tag[i] == tag)) begin
                e_found = 1'b1;
                e_i = i;
            end
        end
        e_hit = e_found && m_valid[e_i];
        if (e_hit) begin
            e_idx = e_i;
        end else begin
            e_idx   = m_ptr;
            e_ev    = m_valid[m_ptr];
            e_evtag = m_tag[m_ptr];
        end

        @(negedge CLK);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_tag   = tag;
        @(negedge CLK);
        req_valid = 1'b0;
        lat = 1;
        while (guard < 400) begin
            refill_ack = 1'b0;
            if (resp_valid) break;
            chk("busy_ready_low", {31'd0, req_ready}, 32'd0);
            if (tcam_tag_update) begin
                chk("upd_ptr", {24'd0, tcam_rep_ptr}, e_idx);
                chk("upd_tag", {4'd0, tcam_tag_in}, {4'd0, tag});
            end
            if (refill_req) begin
                if (!saw_refill) chk("refill_tag", {4'd0, refill_tag}, {4'd0, tag});
                saw_refill = 1'b1;
                k++;
                if (k == ack_dly) refill_ack = 1'b1;
            end
            @(negedge CLK);
            lat++;
            guard++;
        end
        chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
        chk("latency", lat, e_hit ? 2 : 3 + ack_dly);
        chk("refill_seen", {31'd0, saw_refill}, {31'd0, !e_hit});
        chk("resp_hit", {31'd0, resp_hit}, {31'd0, e_hit});
        chk("resp_index", {24'd0, resp_index}, e_idx);
        chk("resp_evict_valid", {31'd0, resp_evict_valid}, {31'd0, e_ev});
        if (e_ev) chk("resp_evict_tag", {4'd0, resp_evict_tag}, {4'd0, e_evtag});
        o_hit = resp_hit; o_idx = resp_index; o_ev = resp_evict_valid; o_evtag = resp_evict_tag;

        for (int h = 0; h < hold; h++) begin
            @(negedge CLK);
            chk("hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("hold_hit", {31'd0, resp_hit}, {31'd0, e_hit});
            chk("hold_index", {24'd0, resp_index}, e_idx);
            chk("hold_ready_low", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);

        if (e_hit) begin
            m_hits++;
        end else begin
            m_misses++;
            if (e_ev) m_evicts++;
            m_tag[m_ptr]   = tag;
            m_wr[m_ptr]    = 1'b1;
            m_valid[m_ptr] = 1'b1;
            m_ptr = (m_ptr + 1) % 256;
        end
    endtask

    initial begin
        logic        h;
        logic [7:0]  ix;
        logic        ev;
        logic [27:0] et;
        logic [27:0] rtag;

        // Reset values.
        repeat (3) @(negedge CLK);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_refill_req", {31'd0, refill_req}, 32'd0);
        chk("rst_update", {31'd0, tcam_tag_update}, 32'd0);
        chk("rst_ptr", {24'd0, tcam_rep_ptr}, 32'd0);
        chk("rst_tag_in", {4'd0, tcam_tag_in}, 32'd0);
        chk("rst_resp_index", {24'd0, resp_index}, 32'd0);
        chk("rst_resp_ev", {31'd0, resp_evict_valid}, 32'd0);
        RST = 1'b0;
        model_clear();

        // First miss, refill ack 4 cycles after refill_req.
        do_req(28'h0000ABC, 4, 0, h, ix, ev, et);
        chk("t1_hit", {31'd0, h}, 32'd0);
        chk("t1_idx", {24'd0, ix}, 32'd0);
        chk("t1_ev", {31'd0, ev}, 32'd0);
        chk("t1_ptr", {24'd0, tcam_rep_ptr}, 32'd1);

        // Same tag hits at index 0.
        do_req(28'h0000ABC, 1, 0, h, ix, ev, et);
        chk("t2_hit", {31'd0, h}, 32'd1);
        chk("t2_idx", {24'd0, ix}, 32'd0);

        // Fill all 256 entries, then force a wrapped eviction.
        do_flush();
        for (int i = 0; i < 256; i++) do_req(28'h1000 + 28'(i), 1 + (i % 3), 0, h, ix, ev, et);
        do_req(28'h2000, 2, 0, h, ix, ev, et);
        chk("t3_idx", {24'd0, ix}, 32'd0);
        chk("t3_ev", {31'd0, ev}, 32'd1);
        chk("t3_evtag", {4'd0, et}, 32'h1000);
        chk("t3_next_ptr", {24'd0, tcam_rep_ptr}, 32'd1);

        // Flush, then a stale TCAM match must miss.
        do_flush();
        do_req(28'h1005, 1, 0, h, ix, ev, et);
        chk("t4_hit", {31'd0, h}, 32'd0);
        chk("t4_idx", {24'd0, ix}, 32'd0);
        chk("t4_ev", {31'd0, ev}, 32'd0);
        // Duplicate now exists at 0 and 5; lowest valid wins; response held 5 cycles.
        do_req(28'h1005, 1, 5, h, ix, ev, et);
        chk("t5_hit", {31'd0, h}, 32'd1);
        chk("t5_idx", {24'd0, ix}, 32'd0);

        // flush wins over a simultaneous request.
        @(negedge CLK);
        flush = 1'b1;
        req_valid = 1'b1;
        req_tag = 28'h5555;
        #1;
        chk("fprio_ready", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        flush = 1'b0;
        req_valid = 1'b0;
        model_clear();
        repeat (3) begin
            @(negedge CLK);
            chk("fprio_no_resp", {30'd0, resp_valid, refill_req}, 32'd0);
        end

        // Randomized traffic with occasional flushes.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) do_flush();
            if ($urandom_range(0, 3) == 0) rtag = 28'h1000 + 28'($urandom_range(0, 255));
            else rtag = 28'h3000 + 28'($urandom_range(0, 7));
            do_req(rtag, $urandom_range(1, 5), $urandom_range(0, 3), h, ix, ev, et);
        end

        // Reset in the middle of a refill.
        @(negedge CLK);
        req_valid = 1'b1;
        req_tag = 28'h4444;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        chk("rr_in_refill", {31'd0, refill_req}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        chk("rr_refill_req", {31'd0, refill_req}, 32'd0);
        chk("rr_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rr_ready", {31'd0, req_ready}, 32'd0);
        chk("rr_ptr", {24'd0, tcam_rep_ptr}, 32'd0);
        RST = 1'b0;
        model_clear();
        m_hits = 0; m_misses = 0; m_evicts = 0;
        @(negedge CLK);
        chk("rr_idle_ready", {31'd0, req_ready}, 32'd1);
        refill_ack = 1'b1;
        @(negedge CLK);
        refill_ack = 1'b0;
        @(negedge CLK);
        chk("rr_late_ack", {29'd0, resp_valid, refill_req, tcam_tag_update}, 32'd0);
        do_req(28'h1005, 2, 0, h, ix, ev, et);
        chk("rr_old_miss", {31'd0, h}, 32'd0);
        do_req(28'h1005, 1, 0, h, ix, ev, et);
        do_req(28'h3001, 3, 1, h, ix, ev, et);

`ifdef TCAM_CTRL_STATS_EN
        chk("stat_hits", hit_count, m_hits);
        chk("stat_misses", miss_count, m_misses);
        chk("stat_evicts", evict_count, m_evicts);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tcam_lookup_ctrl.md
Name: tcam_lookup_ctrl

Overview:
- Sequences the 256-entry, 28-bit tag TCAM for the cache tag path.
- Accepts lookup requests over a valid/ready handshake and reads the TCAM's combinational found/hit_index result.
- On a miss, requests a refill, picks a victim with a round-robin replacement pointer, writes the new tag and reports the evicted tag.
- Sits between the load/store front end and the TCAM plus refill engine.

Parameters:
TAG_W, 28, tag width; must match TCAM tag width.
IDX_W, 8, index width; the TCAM holds 2^IDX_W entries.

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  reset, synchronous, active-high
req_valid  in  1  lookup request valid
req_ready  out  1  controller can accept a request
req_tag  in  TAG_W  tag to look up
resp_valid  out  1  result valid; held until resp_ready
resp_ready  in  1  consumer accepts result
resp_hit  out  1  1 = hit, 0 = miss, now filled
resp_index  out  IDX_W  entry holding the tag
resp_evict_valid  out  1  a valid entry was overwritten
resp_evict_tag  out  TAG_W  tag that was overwritten
refill_req  out  1  miss refill request; level signal
refill_tag  out  TAG_W  tag being refilled
refill_ack  in  1  refill done; single-cycle pulse
flush  in  1  invalidate all entries; single-cycle pulse
tcam_tag_in  out  TAG_W  TCAM search/write tag
tcam_tag_update  out  1  TCAM write strobe
tcam_rep_ptr  out  IDX_W  TCAM write/replace index
tcam_found  in  1  TCAM match
tcam_hit_index  in  IDX_W  lowest matching index
tcam_replaced_tag  in  TAG_W  tag currently stored at tcam_rep_ptr

Behaviour:
- Reset (synchronous, active-high) is highest priority, including mid-operation. On reset:
  - state=IDLE, rep_ptr=0, all 256 valid bits cleared.
  - req_ready=0 during reset, then 1 in IDLE.
  - resp_valid=0, resp_hit=0, resp_index=0, resp_evict_valid=0, resp_evict_tag=0.
  - refill_req=0, tcam_tag_update=0, tcam_tag_in=0, tcam_rep_ptr=0.
- tcam_rep_ptr always equals rep_ptr. tcam_tag_in always equals tag_q.
- IDLE: req_ready=1.
  - flush=1: clear all valid bits, rep_ptr=0, stay in IDLE, req_ready=0 that cycle. flush has priority over a request.
  - req_valid&&req_ready: latch tag_q=req_tag, go to LOOKUP.
- LOOKUP, 1 cycle: hit = tcam_found && valid[tcam_hit_index].
  - Hit: resp_hit=1, resp_index=tcam_hit_index, resp_evict_valid=0, go to RESP.
  - Miss: latch evict_tag=tcam_replaced_tag and evict_v=valid[rep_ptr], go to REFILL.
- Alias rule: a match on an invalid entry counts as a miss. A duplicate entry is tolerated; the priority encoder resolves to the lowest index.
- REFILL: refill_req=1, refill_tag=tag_q. Wait for refill_ack, with no timeout. On ack, go to UPDATE.
- UPDATE, 1 cycle:
  - tcam_tag_update=1; TCAM writes tag_q at rep_ptr on this edge.
  - Set valid[rep_ptr].
  - resp_hit=0, resp_index=rep_ptr, resp_evict_valid=evict_v, resp_evict_tag=evict_tag.
  - rep_ptr advances by 1, wrapping 255 to 0. Go to RESP.
- RESP: resp_valid=1; outputs stable until resp_valid&&resp_ready, then return to IDLE.
  - With resp_ready held high, resp_valid lasts 1 cycle.
  - Next accept is possible the cycle after.
- Latency from the accepting edge to resp_valid:
  - Hit: 2 cycles.
  - Miss: 3 cycles plus refill wait.
- Back-to-back on the same tag: the second request hits, because the write completes before the next LOOKUP.
- flush outside IDLE is ignored. Holding it is the requester's job.
- req_ready=0 in every non-IDLE state.

Optional Feature:
- Macro TCAM_CTRL_STATS_EN.
- Defined: adds outputs hit_count[31:0], miss_count[31:0] and evict_count[31:0].
  - Each increments on the LOOKUP hit, LOOKUP miss, or UPDATE with evict_v=1, respectively.
  - Counters saturate at 0xFFFFFFFF; cleared by RST only, not by flush.
- Undefined: no counter ports or logic; all other behaviour identical.

Test Plan:
- Reset, then req_tag=0x0000ABC with refill_ack 4 cycles after refill_req rises -> UPDATE writes index 0; resp_hit=0, resp_index=0, resp_evict_valid=0; rep_ptr=1.
- Repeat req_tag=0x0000ABC -> resp_valid exactly 2 cycles after accept; resp_hit=1, resp_index=0, no refill_req.
- Fill 256 distinct tags 0x1000..0x10FF, then req_tag=0x2000 -> victim index 0 (rep_ptr wrapped); resp_evict_valid=1, resp_evict_tag=0x1000; next victim is index 1.
- flush in IDLE, then req_tag=0x1005 -> miss despite the stale TCAM match; refill written at index 0, resp_evict_valid=0.
- Assert RST while in REFILL -> next cycle state=IDLE, refill_req=0, resp_valid=0; a later refill_ack is ignored; previous tags now miss.
- resp_ready held low 5 cycles in RESP -> resp_valid, resp_index and resp_hit stay stable; req_ready=0 throughout. With TCAM_CTRL_STATS_EN: after the scenarios above, counters match the expected totals.
